// File: rtl/melody_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : melody_sequencer_if
// Brief   : Control, ROM and note-output signals of the melody sequencer.
// Revision: 1.0
// ============================================================================
interface melody_sequencer_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  enable;
  logic                  restart;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]           rom_data;
  logic [7:0]            pitch;
  logic                  gate;
  logic                  note_start;
  logic                  loop_done;

  modport master (
    input  enable, restart, rom_data,
    output rom_addr, pitch, gate, note_start, loop_done
  );

  modport slave (
    output enable, restart, rom_data,
    input  rom_addr, pitch, gate, note_start, loop_done
  );
endinterface
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : melody_sequencer
// Brief   : Steps through a melody ROM, timing each note in sixteenth units.
//           ARTICULATION_GAP_EN: silence the last GAP_TICKS cycles of each note.
// Revision: 1.0
// ============================================================================
module melody_sequencer #(
  parameter int TICKS_PER_16TH = 750000,
  parameter int MELODY_LENGTH  = 16,
  parameter int ADDR_WIDTH     = 7,
  parameter int CNT_WIDTH      = 28,
  parameter int GAP_TICKS      = 65536
) (
  input  logic               clk,
  input  logic               rst,
  melody_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(MELODY_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0]  c_TICKS = CNT_WIDTH'(TICKS_PER_16TH);
  localparam logic [CNT_WIDTH-1:0]  c_GAP   = CNT_WIDTH'(GAP_TICKS);
  localparam logic [CNT_WIDTH-1:0]  c_ONE   = CNT_WIDTH'(1);
  localparam logic [7:0]            c_REST  = 8'h80;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [CNT_WIDTH-1:0]  r_timer;
  logic [7:0]            r_pitch;
  logic                  r_gate;
  logic                  r_note_start;
  logic                  r_loop_done;

  state_t                w_state_nx;
  logic [ADDR_WIDTH-1:0] w_index_nx;
  logic [CNT_WIDTH-1:0]  w_timer_nx;
  logic [7:0]            w_pitch_nx;
  logic                  w_gate_nx;
  logic                  w_start_nx;
  logic                  w_loop_nx;
  logic [4:0]            w_units;
  logic [CNT_WIDTH-1:0]  w_load;
  logic                  w_unused;

  // Unlisted duration codes fall back to a single sixteenth.
  function automatic logic [4:0] f_units(input logic [5:0] code);
    case (code)
      6'd1:    f_units = 5'd2;
      6'd2:    f_units = 5'd4;
      6'd3:    f_units = 5'd8;
      6'd4:    f_units = 5'd16;
      6'd5:    f_units = 5'd3;
      default: f_units = 5'd1;
    endcase
  endfunction

  assign w_units = f_units(bus.rom_data[5:0]);
  assign w_load  = (CNT_WIDTH'(w_units) * c_TICKS) - c_ONE;

  always_comb begin
    w_state_nx = r_state;
    w_index_nx = r_index;
    w_timer_nx = r_timer;
    w_pitch_nx = r_pitch;
    w_start_nx = 1'b0;
    w_loop_nx  = 1'b0;
    if (!bus.enable) begin
      // Pausing keeps index and pitch; a restart still rewinds the index.
      w_state_nx = S_IDLE;
      if (bus.restart) w_index_nx = '0;
    end else if (bus.restart) begin
      w_state_nx = S_FETCH;
      w_index_nx = '0;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nx = S_FETCH;
        S_FETCH: w_state_nx = S_LOAD;
        S_LOAD: begin
          w_state_nx = S_PLAY;
          w_pitch_nx = bus.rom_data[15:8];
          w_timer_nx = w_load;
          w_start_nx = 1'b1;
        end
        S_PLAY: begin
          if (r_timer == '0) begin
            w_state_nx = S_FETCH;
            if (r_index == c_LAST) begin
              w_index_nx = '0;
              w_loop_nx  = 1'b1;
            end else begin
              w_index_nx = r_index + ADDR_WIDTH'(1);
            end
          end else begin
            w_timer_nx = r_timer - c_ONE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Gate is registered from next-state values so it lines up with PLAY cycles.
`ifdef ARTICULATION_GAP_EN
  assign w_gate_nx = (w_state_nx == S_PLAY) && (w_pitch_nx != c_REST) &&
                     (w_timer_nx >= c_GAP);
  assign w_unused  = &{1'b0, bus.rom_data[7:6]};
`else
  assign w_gate_nx = (w_state_nx == S_PLAY) && (w_pitch_nx != c_REST);
  assign w_unused  = &{1'b0, bus.rom_data[7:6], c_GAP};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_timer      <= '0;
      r_pitch      <= c_REST;
      r_gate       <= 1'b0;
      r_note_start <= 1'b0;
      r_loop_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_index      <= w_index_nx;
      r_timer      <= w_timer_nx;
      r_pitch      <= w_pitch_nx;
      r_gate       <= w_gate_nx;
      r_note_start <= w_start_nx;
      r_loop_done  <= w_loop_nx;
    end
  end

  assign bus.rom_addr   = r_index;
  assign bus.pitch      = r_pitch;
  assign bus.gate       = r_gate;
  assign bus.note_start = r_note_start;
  assign bus.loop_done  = r_loop_done;

endmodule
`default_nettype wire

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_16TH, default 750000, clock cycles per sixteenth-note unit (62.5 ms at 12 MHz).
REQ-002 SHALL have parameter MELODY_LENGTH, default 16, number of ROM entries played before wrapping.
REQ-003 SHALL have parameter ADDR_WIDTH, default 7, ROM address width.
REQ-004 SHALL have parameter CNT_WIDTH, default 28, note-timer width.
REQ-005 SHALL have parameter GAP_TICKS, default 65536, articulation gap length in clocks (used only per REQ-026).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 enable  input  1  level: play when high, pause when low.
REQ-009 restart  input  1  single-cycle pulse: return to note index 0.
REQ-010 rom_addr  output  ADDR_WIDTH  registered address to melody ROM.
REQ-011 rom_data  input  16  ROM word, valid one clock after rom_addr; [15:8] signed pitch, 0x80 = rest; [5:0] duration code.
REQ-012 pitch  output  8  signed semitones from A4 of the current note.
REQ-013 gate  output  1  high while a non-rest note sounds.
REQ-014 note_start  output  1  one-cycle pulse on the first PLAY cycle of every entry, including rests.
REQ-015 loop_done  output  1  one-cycle pulse when the index wraps from MELODY_LENGTH-1 to 0.

Function
REQ-016 SHALL implement states IDLE, FETCH, LOAD, PLAY.
- IDLE->FETCH when enable=1.
- FETCH->LOAD unconditionally; rom_addr = index.
- LOAD->PLAY: latch pitch, compute timer.
- PLAY->FETCH at timer==0 and advance index.
REQ-017 In LOAD, the block SHALL sample rom_data and load the timer with units*TICKS_PER_16TH-1.
- Duration code to units: 0->1, 1->2, 2->4, 3->8, 4->16, 5->3.
- Codes 6..63 -> 1.
REQ-018 The timer SHALL decrement once per PLAY cycle; each entry occupies units*TICKS_PER_16TH PLAY cycles plus 2 overhead cycles (FETCH, LOAD).
REQ-019 gate SHALL be 1 only in PLAY with latched pitch != 0x80; gate SHALL be 0 in IDLE, FETCH, LOAD.
REQ-020 Index advance SHALL be index+1, or 0 with loop_done pulsed in the same cycle when index==MELODY_LENGTH-1.
REQ-021 enable low in any non-IDLE state SHALL go to IDLE on the next edge.
- gate drops; index and pitch are retained.
- Re-enable refetches the same index from its start.
REQ-022 restart SHALL set index to 0 and go to FETCH if enable=1, or IDLE otherwise.
- restart overrides a simultaneous end-of-note advance; no loop_done pulse.
REQ-023 enable=0 SHALL take priority over restart for state; index still clears to 0.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst=1 SHALL asynchronously force:
- state = IDLE, index = 0, rom_addr = 0, timer = 0;
- pitch = 0x80, gate = 0, note_start = 0, loop_done = 0.
Operation SHALL resume on the first edge after rst deasserts.

Configuration
REQ-026 Macro ARTICULATION_GAP_EN:
- Defined: gate SHALL also be 0 during the final GAP_TICKS cycles of each PLAY (timer < GAP_TICKS), separating repeated pitches. If a note is shorter than GAP_TICKS, gate stays 0 for the whole note.
- Undefined: gate follows REQ-019 only, and GAP_TICKS is unused.

Verification (TICKS_PER_16TH=4, MELODY_LENGTH=16, C-scale ROM model with 1-cycle latency)
REQ-027 rst, then enable=1 -> rom_addr=0 in FETCH; note_start pulses 2 cycles later; pitch=-9 (0xF7), gate high 8 cycles; next note_start 10 cycles after the first.
REQ-028 Play index 15 (code 2) -> gate high 16 cycles; loop_done pulses as rom_addr returns to 0; pitch cycles back to -9.
REQ-029 rom_data=0x8002 (rest, quarter) -> note_start pulses, gate=0 for 16 cycles, pitch=0x80; code 6 -> 4 PLAY cycles.
REQ-030 enable dropped mid-note 3, then raised -> gate=0 next cycle, IDLE held; on re-enable FETCH with rom_addr=3 and full 8-cycle note.
REQ-031 restart asserted on the final PLAY cycle of index 15 -> rom_addr=0, no loop_done; rst mid-PLAY -> all outputs at reset values immediately.
REQ-032 With ARTICULATION_GAP_EN and GAP_TICKS=2 -> gate high 6 of 8 PLAY cycles per 8th note; without the macro -> 8 of 8.
